// File: rtl/filter_stim_gen.sv
// On-chip stimulus source for the filter chain: impulse, periodic impulse, step
// or 4-ASK PRBS samples, one per sample strobe, over a start/stop/done run.
module filter_stim_gen #(
  parameter int          WIDTH     = 18,
  parameter int          RUN_LEN   = 256,
  parameter int          PERIOD    = 64,
  parameter logic [14:0] LFSR_SEED = 15'h0001,
  parameter int          CNT_W     = 9
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    smp_en,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [WIDTH-2:0]        amp,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        smp_cnt
);

  localparam int              PH_W    = $clog2(PERIOD);
  localparam logic [14:0]     SEED    = (LFSR_SEED == 15'h0000) ? 15'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(RUN_LEN - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [1:0]        mode_r;
  logic [WIDTH-2:0]  amp_r;
  logic [PH_W-1:0]   phase_r;
  logic [14:0]       lfsr_r;
  logic [WIDTH-2:0]  inner_s;
  logic [WIDTH-1:0]  pos_amp_s;
  logic [WIDTH-1:0]  pos_inner_s;
  logic [WIDTH-1:0]  sample_s;

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; stop overrides everything, start is ignored while running
  always_comb begin
    state_nx_s = state_r;
    if (stop) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) state_nx_s = S_RUN;
          else       state_nx_s = state_r;
        end
        S_RUN: begin
          if (smp_en && (smp_cnt == LAST_N)) state_nx_s = S_DONE;
          else                               state_nx_s = S_RUN;
        end
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // Sample value for the current index; Gray-mapped 4-ASK uses levels +-amp and +-~amp/3
  always_comb begin
    inner_s     = (amp_r >> 2) + (amp_r >> 4) + (amp_r >> 6) + (amp_r >> 8);
    pos_amp_s   = {1'b0, amp_r};
    pos_inner_s = {1'b0, inner_s};
    sample_s    = {WIDTH{1'b0}};
    case (mode_r)
      2'd0: begin
        if (smp_cnt == {CNT_W{1'b0}}) sample_s = pos_amp_s;
        else                          sample_s = {WIDTH{1'b0}};
      end
      2'd1: begin
        if (phase_r == {PH_W{1'b0}}) sample_s = pos_amp_s;
        else                         sample_s = {WIDTH{1'b0}};
      end
      2'd2: sample_s = pos_amp_s;
      2'd3: begin
        case (lfsr_r[1:0])
          2'b00:   sample_s = {WIDTH{1'b0}} - pos_amp_s;
          2'b01:   sample_s = {WIDTH{1'b0}} - pos_inner_s;
          2'b11:   sample_s = pos_inner_s;
          2'b10:   sample_s = pos_amp_s;
          default: sample_s = {WIDTH{1'b0}};
        endcase
      end
      default: sample_s = {WIDTH{1'b0}};
    endcase
  end

  // Registered outputs and run datapath
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      x_out   <= {WIDTH{1'b0}};
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      smp_cnt <= {CNT_W{1'b0}};
      mode_r  <= 2'd0;
      amp_r   <= {(WIDTH-1){1'b0}};
      phase_r <= {PH_W{1'b0}};
      lfsr_r  <= SEED;
    end else begin
      busy    <= (state_nx_s == S_RUN);
      done    <= (state_nx_s == S_DONE);
      x_valid <= 1'b0;
      if (stop) begin
        x_out <= {WIDTH{1'b0}};
      end else if (state_r == S_RUN) begin
        if (smp_en) begin
          x_out   <= sample_s;
          x_valid <= 1'b1;
          smp_cnt <= smp_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          phase_r <= (phase_r == LAST_PH) ? {PH_W{1'b0}} : phase_r + {{(PH_W-1){1'b0}}, 1'b1};
          lfsr_r  <= {lfsr_r[13:0], lfsr_r[14] ^ lfsr_r[13]};
        end else begin
          x_out <= x_out;
        end
      end else if (start) begin
        mode_r  <= mode;
        amp_r   <= amp;
        smp_cnt <= {CNT_W{1'b0}};
        phase_r <= {PH_W{1'b0}};
        lfsr_r  <= SEED;
      end else if ((state_r == S_DONE) && smp_en) begin
        x_out <= {WIDTH{1'b0}};
      end else begin
        x_out <= x_out;
      end
    end
  end

endmodule

// File: doc/filter_stim_gen.md
Name: filter_stim_gen

Overview:
- Synthesizable, parametrised stimulus source for the filter chain; replaces file-driven x_in with on-chip sequences.
- Produces impulse, periodic-impulse, step or 4-ASK PRBS samples, one per sample-enable strobe (sys_clk2_en for halfband, sam_clk_en for sample-rate filters).
- Runs for a programmable number of samples under a start/done handshake, so impulse and symbol responses can be captured in hardware or in simulation without text files.

Parameters:
- WIDTH, 18, sample width, signed 1sWIDTH-1.
- RUN_LEN, 256, samples emitted per run (>=1).
- PERIOD, 64, sample spacing of impulses in mode 1 (>=2).
- LFSR_SEED, 15'h0001, LFSR load value on start; a zero seed is forced to 15'h0001.
- CNT_W, 9, width of smp_cnt; must hold RUN_LEN.

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- smp_en  in  1  one-cycle sample strobe
- start  in  1  begin run; sampled every sys_clk
- stop  in  1  abort run
- mode  in  2  0 single impulse, 1 periodic impulse, 2 step, 3 4-ASK PRBS
- amp  in  WIDTH-1  unsigned outer amplitude
- x_out  out  WIDTH  signed stimulus sample (registered)
- x_valid  out  1  one-cycle pulse when x_out updates with a run sample
- busy  out  1  high in RUN
- done  out  1  high in DONE
- smp_cnt  out  CNT_W  samples emitted in the current or last run

Behaviour:
- Reset (rst=1 at a sys_clk edge): state IDLE; x_out=0, x_valid=0, busy=0, done=0, smp_cnt=0, LFSR=seed.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 (stop=0):
  - Latch mode into mode_r and amp into amp_r.
  - Clear smp_cnt and the periodic phase counter; load LFSR.
  - Go to RUN; done falls on the same edge.
  - mode/amp changes during RUN are ignored.
- RUN, smp_en=1:
  - x_out <= f(mode_r, n), where n = smp_cnt before the edge.
  - x_valid=1 for that cycle only; smp_cnt <= n+1.
- RUN, smp_en=0: all outputs hold; x_valid=0.
- Sample functions (inner = (amp_r>>2)+(amp_r>>4)+(amp_r>>6)+(amp_r>>8), truncating shifts):
  - mode 0: amp_r at n=0, else 0.
  - mode 1: amp_r when phase==0, else 0; phase counts 0..PERIOD-1 per emitted sample and wraps.
  - mode 2: amp_r for every n.
  - mode 3: symbol s = LFSR[1:0] (Gray mapping):
    - 00 -> -amp_r
    - 01 -> -inner
    - 11 -> +inner
    - 10 -> +amp_r
    - Then LFSR <= {LFSR[13:0], LFSR[14]^LFSR[13]}, advancing once per emitted sample.
- Negation is two's complement at WIDTH bits. amp is WIDTH-1 bits, so no overflow occurs.
- The edge emitting sample n=RUN_LEN-1 also moves to DONE:
  - busy falls and done rises on that edge.
  - smp_cnt=RUN_LEN.
- DONE:
  - First smp_en clears x_out to 0, with no x_valid.
  - smp_cnt holds.
  - done stays high until start or rst.
- start and smp_en on the same edge in IDLE/DONE: only the transition to RUN occurs; the first sample is emitted on the next smp_en.
- start while in RUN: ignored.
- stop=1 (any state, priority over start): next state IDLE, x_out=0, x_valid=0, busy=0, done=0; smp_cnt holds.
- stop and smp_en on the same edge: no sample is emitted.
- rst mid-run: full reset as above; no further samples emitted.
- Latency: x_out/x_valid update on the sys_clk edge where smp_en=1, i.e. one register stage from the strobe.

Test Plan:
- Impulse: rst, mode=0, amp=131071, start, smp_en every 2nd cycle -> x_out 131071 with x_valid on 1st strobe, then 0 for 255 strobes; done after 256 strobes; smp_cnt=256; next strobe keeps x_out=0 with no x_valid.
- Periodic: mode=1, amp=1000, PERIOD=64 -> x_out=1000 at n=0,64,128,192; 0 elsewhere; exactly 4 nonzero valid samples.
- 4-ASK: mode=3, amp=1024, seed 1 -> first three samples -340, +1024, -1024 (LFSR 0001, 0002, 0004); all 256 samples in {±1024, ±340}.
- Handshake: start asserted together with smp_en in IDLE -> no x_valid that cycle; first sample on next strobe. start pulsed mid-run -> run unaffected; smp_cnt still 256.
- Abort: mode=2, amp=500, stop after 10 samples -> x_out=0, busy=0, done=0, smp_cnt=10; restart with start -> smp_cnt=0 then counts again.
- Reset mid-run: rst for one cycle at n=100 -> all outputs 0 next edge; no x_valid until a new start.
